// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg_pkg
//  Brief    : Shared defaults for the pipeline stage register slice.
//  Revision : 1.0
// ============================================================================
package pipe_stage_reg_pkg;

    localparam int unsigned c_data_w_default = 64;
    localparam int unsigned c_cnt_w_default  = 32;

endpackage : pipe_stage_reg_pkg
`default_nettype wire

// File: rtl/pipe_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_perf_cnt
//  Brief    : Saturating event counter with synchronous clear (clear wins).
//  Revision : 1.0
// ============================================================================
module pipe_perf_cnt
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned CNT_W = c_cnt_w_default
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = &r_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !w_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule : pipe_perf_cnt
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Brief    : Pipeline stage register, valid/ready with 2-entry skid and flush.
//             Optional perf counters enabled by macro PIPE_PERF_CNT_EN.
//  Revision : 1.0
// ============================================================================
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned       DATA_W   = c_data_w_default,
    parameter logic [DATA_W-1:0] RST_DATA = '0,
    parameter int unsigned       CNT_W    = c_cnt_w_default
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_PERF_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_stall,
    output logic [CNT_W-1:0]  cnt_bubble
`endif
);

    if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
        $error("pipe_stage_reg: DATA_W and CNT_W must be at least 1");
    end

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_in_ready;

    logic              w_in_fire;
    logic              w_main_load;
    logic              w_out_valid_nxt;
    logic [DATA_W-1:0] w_out_data_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;

    assign w_in_fire   = in_valid & r_in_ready;
    assign w_main_load = !r_out_valid | out_ready;

    always_comb begin
        w_out_valid_nxt  = r_out_valid;
        w_out_data_nxt   = r_out_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        if (flush) begin
            // Kill everything; payload registers keep their last contents.
            w_out_valid_nxt  = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_main_load) begin
            if (r_skid_valid) begin
                w_out_valid_nxt  = 1'b1;
                w_out_data_nxt   = r_skid_data;
                w_skid_valid_nxt = w_in_fire;
                if (w_in_fire) begin
                    w_skid_data_nxt = in_data;
                end
            end else if (w_in_fire) begin
                w_out_valid_nxt = 1'b1;
                w_out_data_nxt  = in_data;
            end else begin
                w_out_valid_nxt = 1'b0;
            end
        end else if (w_in_fire && !r_skid_valid) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = in_data;
        end
    end

    // in_ready is its own flop so no combinational path reaches upstream.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= RST_DATA;
            r_skid_valid <= 1'b0;
            r_skid_data  <= RST_DATA;
            r_in_ready   <= 1'b1;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

`ifdef PIPE_PERF_CNT_EN
    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt_stall (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (cnt_clr),
        .inc     (r_out_valid & !out_ready),
        .cnt     (cnt_stall)
    );

    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt_bubble (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (cnt_clr),
        .inc     (!r_out_valid),
        .cnt     (cnt_bubble)
    );
`endif

endmodule : pipe_stage_reg
`default_nettype wire
